// File: rtl/my_prim_pkg.sv
// my_prim_pkg: sizing helpers and parameter legality check shared by the SRL FIFO files
package my_prim_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction
  function automatic bit params_ok(input int width, input int depth, input int thresh);
    return width >= 1 && depth >= 2 && depth <= 256 && (depth & (depth - 1)) == 0 &&
           thresh >= 1 && thresh <= depth;
  endfunction
endpackage

// File: rtl/my_srl_fifo_if.sv
// my_srl_fifo_if: FIFO handshake/status bundle
//   flush, in_data/in_valid/in_ready (write side), out_data/out_valid/out_ready (read side),
//   count, full, empty, almost_full (status); master drives writes/reads, slave is the FIFO
interface my_srl_fifo_if #(parameter int WIDTH = 8, parameter int DEPTH = 16);
  import my_prim_pkg::*;
  localparam int CW = cnt_w(DEPTH);
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  modport master (output flush, in_data, in_valid, out_ready,
                  input in_ready, out_data, out_valid, count, full, empty, almost_full);
  modport slave (input flush, in_data, in_valid, out_ready,
                 output in_ready, out_data, out_valid, count, full, empty, almost_full);
endinterface

// File: rtl/my_srl_store.sv
// my_srl_store: WIDTH x DEPTH shift array, shifts on i_ce, addressable read tap
//   i_clk clock, i_ce shift enable, i_d data into entry 0, i_addr tap select, o_q tapped entry
module my_srl_store
  import my_prim_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  input  logic [AW-1:0]    i_addr,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_ce) begin
      r_mem[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
    end
  end
  assign o_q = r_mem[i_addr];
endmodule

// File: rtl/my_srl_fifo.sv
// my_srl_fifo: shift-register FIFO with valid/ready handshakes, status flags and flush
//   i_clk clock, i_clr_n async active-low reset, bus FIFO interface (slave side)
module my_srl_fifo
  import my_prim_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input logic          i_clk,
  input logic          i_clr_n,
  my_srl_fifo_if.slave bus
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = clog2(DEPTH);
  if (!params_ok(WIDTH, DEPTH, AFULL_THRESH)) begin : g_bad_params
    $error("my_srl_fifo: illegal WIDTH/DEPTH/AFULL_THRESH");
  end
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_tap;
  logic          w_push;
  logic          w_pop;
  assign bus.full        = r_count == CW'(DEPTH);
  assign bus.empty       = r_count == '0;
  assign bus.almost_full = r_count >= CW'(AFULL_THRESH);
  assign bus.in_ready    = ~bus.full;
  assign bus.out_valid   = ~bus.empty;
  assign bus.count       = r_count;
  assign w_push = bus.in_valid & ~bus.full;
  assign w_pop  = bus.out_ready & ~bus.empty;
  // oldest entry sits at count-1; empty taps entry 0 (don't-care)
  assign w_tap = bus.empty ? '0 : r_count - CW'(1);
  always_comb begin
    w_count_nxt = bus.flush          ? '0 :
                  (w_push & ~w_pop)  ? r_count + CW'(1) :
                  (w_pop & ~w_push)  ? r_count - CW'(1) : r_count;
  end
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) r_count <= '0;
    else          r_count <= w_count_nxt;
  end
  my_srl_store #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_store (
    .i_clk  (i_clk),
    .i_ce   (w_push),
    .i_d    (bus.in_data),
    .i_addr (w_tap[AW-1:0]),
    .o_q    (bus.out_data)
  );
endmodule

// File: tb/tb_my_srl_fifo.sv
// tb_my_srl_fifo: scoreboard bench for my_srl_fifo (WIDTH 8, DEPTH 16, AFULL_THRESH 14)
module tb_my_srl_fifo;
  logic clk = 0;
  logic clr_n = 0;
  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  my_srl_fifo_if #(.WIDTH(8), .DEPTH(16)) bus ();
  my_srl_fifo #(.WIDTH(8), .DEPTH(16), .AFULL_THRESH(14)) dut (
    .i_clk   (clk),
    .i_clr_n (clr_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    checks++;
    if (bus.count > 5'd16) begin
      failures++;
      $display("FAIL count_bound actual=%0d required<=16", bus.count);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
    bit push, pop;
    logic [7:0] exp;
    bus.in_valid = v; bus.in_data = d; bus.out_ready = r; bus.flush = f;
    push = v && q.size() < 16;
    pop = r && q.size() > 0;
    #1;
    if (pop) begin
      exp = q.pop_front();
      checks++;
      if (bus.out_data !== exp) begin
        failures++;
        $display("FAIL pop_data actual=%h required=%h", bus.out_data, exp);
      end
    end
    if (push) q.push_back(d);
    if (f) q.delete();
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 0; bus.out_ready = 0; bus.flush = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 32 && q.size() > 0; i++) step(0, 8'h00, 1, 0);
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
      failures++;
      $display("FAIL drain_empty actual=%b/%0d required=1/0", bus.empty, bus.count);
    end
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if ({bus.count, bus.empty, bus.full, bus.out_valid, bus.in_ready, bus.almost_full} !== {5'd0, 5'b10010}) begin
      failures++;
      $display("FAIL reset cnt=%0d e=%b f=%b ov=%b ir=%b af=%b required 0,1,0,0,1,0",
               bus.count, bus.empty, bus.full, bus.out_valid, bus.in_ready, bus.almost_full);
    end
    @(negedge clk);
    clr_n = 1;
    @(negedge clk);
  endtask
  task automatic test_basic();
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    checks++;
    if (bus.count !== 5'(q.size()) || bus.out_data !== 8'h11 || bus.empty !== 1'b0) begin
      failures++;
      $display("FAIL basic cnt=%0d data=%h empty=%b required 3,11,0", bus.count, bus.out_data, bus.empty);
    end
    drain();
  endtask
  task automatic test_fill();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    checks++;
    if (bus.full !== 1'b1 || bus.in_ready !== 1'b0 || bus.count !== 5'd16) begin
      failures++;
      $display("FAIL fill full=%b ir=%b cnt=%0d required 1,0,16", bus.full, bus.in_ready, bus.count);
    end
    step(1, 8'hFF, 0, 0);
    checks++;
    if (bus.count !== 5'(q.size()) || bus.out_data !== 8'h00) begin
      failures++;
      $display("FAIL push_full cnt=%0d data=%h required %0d,00", bus.count, bus.out_data, q.size());
    end
    drain();
  endtask
  task automatic test_almost_full();
    for (int i = 0; i < 13; i++) step(1, 8'(8'h40 + i), 0, 0);
    checks++;
    if (bus.almost_full !== 1'b0) begin
      failures++;
      $display("FAIL af_13 actual=%b required=0", bus.almost_full);
    end
    step(1, 8'h4D, 0, 0);
    checks++;
    if (bus.almost_full !== 1'b1 || bus.count !== 5'd14) begin
      failures++;
      $display("FAIL af_14 actual=%b cnt=%0d required=1,14", bus.almost_full, bus.count);
    end
    step(0, 8'h00, 1, 0);
    checks++;
    if (bus.almost_full !== 1'b0 || bus.count !== 5'd13) begin
      failures++;
      $display("FAIL af_back13 actual=%b cnt=%0d required=0,13", bus.almost_full, bus.count);
    end
    drain();
  endtask
  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hAA, 1, 0);
    checks++;
    if (bus.count !== 5'd5 || bus.count !== 5'(q.size())) begin
      failures++;
      $display("FAIL simul_count actual=%0d required=5", bus.count);
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    checks++;
    if (bus.out_data !== 8'hAA || bus.count !== 5'd1) begin
      failures++;
      $display("FAIL simul_last data=%h cnt=%0d required AA,1", bus.out_data, bus.count);
    end
    drain();
  endtask
  task automatic test_flush();
    for (int i = 0; i < 7; i++) step(1, 8'(8'h70 + i), 0, 0);
    step(1, 8'h77, 0, 1);
    checks++;
    if (bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush cnt=%0d ov=%b required 0,0", bus.count, bus.out_valid);
    end
    step(1, 8'h5A, 0, 0);
    step(1, 8'h5B, 0, 0);
    drain();
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) step(1, 8'(8'h90 + i), 0, 0);
    #2 clr_n = 0;
    #1;
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset cnt=%0d e=%b ir=%b required 0,1,1", bus.count, bus.empty, bus.in_ready);
    end
    q.delete();
    @(negedge clk);
    clr_n = 1;
    @(negedge clk);
    step(1, 8'h3C, 0, 0);
    checks++;
    if (bus.count !== 5'd1 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL resume cnt=%0d ov=%b required 1,1", bus.count, bus.out_valid);
    end
    drain();
  endtask
  initial begin
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0; bus.flush = 0;
    test_reset();
    test_basic();
    test_fill();
    test_almost_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/my_srl_fifo.md
# my_srl_fifo

Parametrised shift-register FIFO: the generalised successor of the 16-deep, 1-bit addressable shift-register primitive. Storage is a WIDTH-bit × DEPTH-entry shift array whose read tap is driven by an internal occupancy counter, so the oldest entry is always presented at the output. It provides valid/ready handshakes on both sides, status flags and a synchronous flush. It sits between pipeline stages that need shallow, cheap elasticity without a RAM.

## Interface
- WIDTH, 8, data bits per entry (≥1)
- DEPTH, 16, entries; power of two, 2..256
- AFULL_THRESH, DEPTH-2, ALMOST_FULL asserts when COUNT ≥ this value (1..DEPTH)

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- CLR_N  in  1  reset, asynchronous, active-low
- FLUSH  in  1  synchronous clear of occupancy
- IN_DATA  in  WIDTH  write data
- IN_VALID  in  1  write request
- IN_READY  out  1  FIFO can accept data
- OUT_DATA  out  WIDTH  oldest entry
- OUT_VALID  out  1  OUT_DATA holds a valid entry
- OUT_READY  in  1  consumer accepts OUT_DATA
- COUNT  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
- FULL, EMPTY, ALMOST_FULL  out  1 each  status flags

## Operation
- push = IN_VALID & IN_READY; pop = OUT_VALID & OUT_READY.
- IN_READY = ~FULL; OUT_VALID = ~EMPTY; FULL = (COUNT == DEPTH); EMPTY = (COUNT == 0); ALMOST_FULL = (COUNT ≥ AFULL_THRESH). All are combinational decodes of COUNT.
- Storage: on push, every entry shifts by one (entry i ← entry i-1) and entry 0 ← IN_DATA. Storage has no reset and no clock enable other than push.
- OUT_DATA = entry[COUNT-1] (combinational tap). When EMPTY, OUT_DATA is entry[0] and is don't-care.
- COUNT update, in priority order: FLUSH → 0; push & ~pop → +1; pop & ~push → −1; push & pop → unchanged, and the tap then selects the next-oldest entry because of the shift; neither → unchanged.
- When full, IN_READY = 0, so no push occurs, even if a pop occurs in the same cycle. Write throughput at full is one cycle behind the pop.
- When empty, OUT_VALID = 0, so no pop occurs. There is no fall-through: a pushed entry is visible the following cycle.
- FLUSH with simultaneous push: the push shifts storage, but COUNT still goes to 0, so the entry is discarded.
- COUNT arithmetic never wraps. The handshake rules make overflow and underflow impossible. The bench asserts COUNT ≤ DEPTH.

## Timing
- Reset (CLR_N low, asynchronous): COUNT = 0, EMPTY = 1, FULL = 0, OUT_VALID = 0, IN_READY = 1, ALMOST_FULL = 0 (AFULL_THRESH ≥ 1). OUT_DATA is undefined. Release is synchronous to the next CLK edge.
- Reset mid-operation: occupancy is lost immediately. Storage contents are retained but unreachable.
- Write-to-read latency: 1 cycle (push at edge N; OUT_VALID high after edge N when previously empty).
- Read-to-next-data: 0 cycles. After a pop at edge N, the next entry is on OUT_DATA immediately after edge N.
- Flags update on the same edge as COUNT. There is no registered look-ahead.
- Combinational paths: OUT_READY does not feed IN_READY, and IN_VALID does not feed OUT_VALID.

## Structure
- Package my_prim_pkg: clog2 constant function, the COUNT-width localparam formula, and a parameter legality check (DEPTH power of two, AFULL_THRESH range) with an elaboration-time error.
- Sub-module my_srl_store (WIDTH, DEPTH): shift array with CE = push plus an addressable tap. This is the direct generalisation of the 16-entry primitive. my_srl_fifo wraps it with the counter, flags and handshake logic.

## Test plan
- Reset then 3 pushes of 0x11, 0x22, 0x33, no pops → COUNT = 3; OUT_DATA = 0x11; EMPTY = 0.
- DEPTH = 16: fill with 0..15 → FULL = 1, IN_READY = 0. A push of 0xFF while full is ignored. Pops return 0..15 in order, then EMPTY = 1.
- COUNT = 5 with push (0xAA) and pop on the same cycle → COUNT stays 5. The popped value is the oldest entry, and 0xAA is read out 5 pops later.
- AFULL_THRESH = 14, DEPTH = 16 → ALMOST_FULL rises on the edge COUNT reaches 14 and falls when COUNT returns to 13.
- COUNT = 7, FLUSH together with a push → next cycle COUNT = 0 and OUT_VALID = 0. A subsequent push of 0x5A is output first.
- COUNT = 9, CLR_N pulsed low between edges → COUNT = 0, EMPTY = 1 and IN_READY = 1 without waiting for a CLK edge. Normal operation resumes after release.
